obstacle_field: RTL and testbench

Parametrised multi-slot obstacle generator and scroller for the dino game, the successor to the fixed two-obstacle `obstacles` block. It holds NUM_OBS independent obstacle slots, spawns into free slots using the LFSR byte with a randomised minimum gap, and scrolls active slots left once per 60 Hz game tick. Scroll speed ramps over time up to a cap. Outputs feed one `obs_render`/`obs_rom` pair per slot and sit between `player_controller` and the graphics pipeline.

---
 rtl/obstacle_field.sv | 159 +++++++++++++++
 tb/tb_obstacle_field.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_field.sv
// Multi-slot obstacle field: spawns obstacles into free slots with a randomised
// gap and scrolls active slots left on each game tick, with a speed ramp.
module obstacle_field #(
    parameter int NUM_OBS    = 4,
    parameter int CONV       = 2,
    parameter int SPAWN_X    = 640 >> CONV,
    parameter int NUM_TYPES  = 6,
    parameter int MIN_GAP    = 20,
    parameter int SPEED_INIT = 1,
    parameter int SPEED_MAX  = 4,
    parameter int RAMP_TICKS = 600
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_game_start,
    input  logic                         i_game_frozen,
    input  logic                         i_game_tick,
    input  logic [7:0]                   i_rng,
    output logic [NUM_OBS*(10-CONV)-1:0] o_obs_pos,
    output logic [3*NUM_OBS-1:0]         o_obs_type,
    output logic [NUM_OBS-1:0]           o_obs_active,
    output logic [3:0]                   o_speed,
    output logic                         o_spawn_pulse
);
    localparam int W  = 10 - CONV;
    localparam int GW = $clog2(MIN_GAP + 32);
    localparam int RW = $clog2(RAMP_TICKS + 1);
    localparam logic [3:0] NT4 = 4'(NUM_TYPES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FROZEN} state_t;

    state_t r_state, w_state_nxt;
    logic   w_clear, w_do_tick;

    logic [W-1:0]      r_pos [NUM_OBS];
    logic [2:0]        r_type [NUM_OBS];
    logic [NUM_OBS-1:0] r_active;
    logic [3:0]        r_speed;
    logic [GW-1:0]     r_gap;
    logic [RW-1:0]     r_ramp;
    logic              r_spawn;

    logic [W-1:0]      w_pos_nxt [NUM_OBS];
    logic [2:0]        w_type_nxt [NUM_OBS];
    logic [NUM_OBS-1:0] w_active_nxt;
    logic [3:0]        w_speed_nxt;
    logic [GW-1:0]     w_gap_nxt;
    logic [RW-1:0]     w_ramp_nxt;
    logic              w_spawn;
    logic              w_found;
    logic [W-1:0]      w_speed_ext;
    logic [2:0]        w_type_sp;
    logic [RW-1:0]     w_ramp_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // A start pulse overrides everything, including a coincident freeze.
    always_comb begin
        w_state_nxt = r_state;
        if (i_game_start) begin
            w_state_nxt = S_RUN;
        end else begin
            case (r_state)
                S_RUN:    if (i_game_frozen) w_state_nxt = S_FROZEN;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_clear   = i_game_start;
        w_do_tick = (r_state == S_RUN) && i_game_tick && !i_game_start;
    end

    assign w_speed_ext = W'(r_speed);
    assign w_type_sp   = ({1'b0, i_rng[2:0]} >= NT4) ? (i_rng[2:0] - NT4[2:0]) : i_rng[2:0];
    assign w_ramp_inc  = r_ramp + RW'(1);

    always_comb begin
        w_pos_nxt    = r_pos;
        w_type_nxt   = r_type;
        w_active_nxt = r_active;
        w_speed_nxt  = r_speed;
        w_gap_nxt    = r_gap;
        w_ramp_nxt   = r_ramp;
        w_spawn      = 1'b0;
        w_found      = 1'b0;
        if (w_do_tick) begin
            // Freeness is judged on the pre-tick active mask, so a slot that
            // exits on this tick cannot be refilled until the next one.
            for (int k = 0; k < NUM_OBS; k++) begin
                if (r_active[k]) begin
                    if (r_pos[k] >= w_speed_ext) begin
                        w_pos_nxt[k] = r_pos[k] - w_speed_ext;
                    end else begin
                        w_active_nxt[k] = 1'b0;
                        w_pos_nxt[k]    = '1;
                    end
                end else if (r_gap == '0 && !w_found) begin
                    w_found         = 1'b1;
                    w_active_nxt[k] = 1'b1;
                    w_pos_nxt[k]    = W'(SPAWN_X);
                    w_type_nxt[k]   = w_type_sp;
                end
            end
            if (w_found) begin
                w_spawn   = 1'b1;
                w_gap_nxt = GW'(MIN_GAP) + GW'(i_rng[7:3]);
            end else if (r_gap != '0) begin
                w_gap_nxt = r_gap - GW'(1);
            end
            if (w_ramp_inc == RW'(RAMP_TICKS)) begin
                w_ramp_nxt  = '0;
                w_speed_nxt = (r_speed < 4'(SPEED_MAX)) ? r_speed + 4'd1 : r_speed;
            end else begin
                w_ramp_nxt = w_ramp_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || w_clear) begin
            for (int k = 0; k < NUM_OBS; k++) begin
                r_pos[k]  <= '1;
                r_type[k] <= '0;
            end
            r_active <= '0;
            r_speed  <= 4'(SPEED_INIT);
            r_gap    <= GW'(MIN_GAP);
            r_ramp   <= '0;
            r_spawn  <= 1'b0;
        end else begin
            r_pos    <= w_pos_nxt;
            r_type   <= w_type_nxt;
            r_active <= w_active_nxt;
            r_speed  <= w_speed_nxt;
            r_gap    <= w_gap_nxt;
            r_ramp   <= w_ramp_nxt;
            r_spawn  <= w_spawn;
        end
    end

    always_comb begin
        o_obs_pos  = '0;
        o_obs_type = '0;
        for (int k = 0; k < NUM_OBS; k++) begin
            o_obs_pos[k*W +: W]  = r_pos[k];
            o_obs_type[3*k +: 3] = r_type[k];
        end
    end

    assign o_obs_active  = r_active;
    assign o_speed       = r_speed;
    assign o_spawn_pulse = r_spawn;

endmodule

// File: tb/tb_obstacle_field.sv
// Bench for obstacle_field: a default instance and a small two-slot instance
// share stimulus and are compared every cycle against a behavioural model.
module tb_obstacle_field;
    logic       clk = 1'b0;
    logic       rst;
    logic       i_game_start, i_game_frozen, i_game_tick;
    logic [7:0] i_rng;

    logic [31:0] pos0;  logic [11:0] type0; logic [3:0] act0; logic [3:0] spd0; logic sp0;
    logic [15:0] pos1;  logic [5:0]  type1; logic [1:0] act1; logic [3:0] spd1; logic sp1;

    always #5 clk = ~clk;

    obstacle_field dut0 (
        .clk(clk), .rst(rst), .i_game_start(i_game_start), .i_game_frozen(i_game_frozen),
        .i_game_tick(i_game_tick), .i_rng(i_rng), .o_obs_pos(pos0), .o_obs_type(type0),
        .o_obs_active(act0), .o_speed(spd0), .o_spawn_pulse(sp0)
    );

    obstacle_field #(.NUM_OBS(2), .MIN_GAP(0), .RAMP_TICKS(2), .SPEED_MAX(3)) dut1 (
        .clk(clk), .rst(rst), .i_game_start(i_game_start), .i_game_frozen(i_game_frozen),
        .i_game_tick(i_game_tick), .i_rng(i_rng), .o_obs_pos(pos1), .o_obs_type(type1),
        .o_obs_active(act1), .o_speed(spd1), .o_spawn_pulse(sp1)
    );

    // Reference model: one entry per instance.
    localparam int IDLE = 0, RUN = 1, FROZEN = 2;
    int P_NOBS[2] = '{4, 2};
    int P_GAP[2]  = '{20, 0};
    int P_RAMP[2] = '{600, 2};
    int P_SMAX[2] = '{4, 3};

    int m_pos[2][8], m_type[2][8];
    bit m_act[2][8];
    int m_speed[2], m_gap[2], m_ramp[2], m_state[2];
    bit m_spawn[2];

    int n_cmp = 0, n_err = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_clear(int i);
        for (int k = 0; k < 8; k++) begin
            m_act[i][k] = 0; m_pos[i][k] = 255; m_type[i][k] = 0;
        end
        m_speed[i] = 1; m_gap[i] = P_GAP[i]; m_ramp[i] = 0; m_spawn[i] = 0;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 2; i++) begin
            m_clear(i); m_state[i] = IDLE;
        end
    endfunction

    function automatic void m_tick(int i, int r);
        bit was_free[8];
        bit done = 0;
        for (int k = 0; k < P_NOBS[i]; k++) was_free[k] = !m_act[i][k];
        for (int k = 0; k < P_NOBS[i]; k++) begin
            if (m_act[i][k]) begin
                if (m_pos[i][k] >= m_speed[i]) m_pos[i][k] -= m_speed[i];
                else begin m_act[i][k] = 0; m_pos[i][k] = 255; end
            end
        end
        if (m_gap[i] == 0) begin
            for (int k = 0; k < P_NOBS[i]; k++) begin
                if (was_free[k] && !done) begin
                    done = 1;
                    m_act[i][k] = 1; m_pos[i][k] = 160;
                    m_type[i][k] = (r % 8 >= 6) ? (r % 8) - 6 : r % 8;
                    m_gap[i] = P_GAP[i] + r / 8;
                    m_spawn[i] = 1;
                end
            end
        end else begin
            m_gap[i]--;
        end
        m_ramp[i]++;
        if (m_ramp[i] == P_RAMP[i]) begin
            m_ramp[i] = 0;
            if (m_speed[i] + 1 <= P_SMAX[i]) m_speed[i]++;
        end
    endfunction

    function automatic void m_update(bit s, bit f, bit t, int r);
        for (int i = 0; i < 2; i++) begin
            m_spawn[i] = 0;
            if (s) begin
                m_clear(i); m_state[i] = RUN;
            end else if (m_state[i] == RUN) begin
                if (t) m_tick(i, r);
                if (f) m_state[i] = FROZEN;
            end
        end
    endfunction

    function automatic logic [63:0] e_pos(int i);
        logic [63:0] v = '0;
        for (int k = 0; k < P_NOBS[i]; k++) v[k*8 +: 8] = 8'(m_pos[i][k]);
        return v;
    endfunction

    function automatic logic [63:0] e_type(int i);
        logic [63:0] v = '0;
        for (int k = 0; k < P_NOBS[i]; k++) v[k*3 +: 3] = 3'(m_type[i][k]);
        return v;
    endfunction

    function automatic logic [63:0] e_act(int i);
        logic [63:0] v = '0;
        for (int k = 0; k < P_NOBS[i]; k++) v[k] = m_act[i][k];
        return v;
    endfunction

    task automatic compare_all();
        check("d0_pos", pos0, e_pos(0));  check("d0_type", type0, e_type(0));
        check("d0_act", act0, e_act(0));  check("d0_speed", spd0, m_speed[0]);
        check("d0_pulse", sp0, m_spawn[0]);
        check("d1_pos", pos1, e_pos(1));  check("d1_type", type1, e_type(1));
        check("d1_act", act1, e_act(1));  check("d1_speed", spd1, m_speed[1]);
        check("d1_pulse", sp1, m_spawn[1]);
    endtask

    task automatic step(bit s, bit t, logic [7:0] r);
        i_game_start = s; i_game_tick = t; i_rng = r;
        @(posedge clk);
        m_update(s, i_game_frozen, t, r);
        #1;
        i_game_start = 0; i_game_tick = 0;
        compare_all();
    endtask

    task automatic tick(logic [7:0] r);
        step(0, 1, r);
        step(0, 0, r);
    endtask

    logic [63:0] saved_pos, saved_act;
    int n_pulse;

    initial begin
        rst = 1; i_game_start = 0; i_game_frozen = 0; i_game_tick = 0; i_rng = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 0;

        // No start: ticks are ignored.
        n_pulse = 0;
        for (int t = 0; t < 100; t++) begin
            step(0, 1, 8'($urandom));
            n_pulse += int'(sp0) + int'(sp1);
            step(0, 0, 0);
        end
        check("idle_no_pulse", n_pulse, 0);
        check("idle_pos", pos0, 32'hFFFF_FFFF);

        // Directed run with i_rng = 0.
        step(1, 0, 0);
        for (int t = 1; t <= 200; t++) begin
            step(0, 1, 0);
            if (t <= 20) check("pre_spawn_pulse", sp0, 0);
            if (t == 21) begin
                check("t21_pulse", sp0, 1); check("t21_act0", act0[0], 1);
                check("t21_pos0", pos0[7:0], 160); check("t21_type0", type0[2:0], 0);
            end
            if (t == 22) check("t22_pos0", pos0[7:0], 159);
            if (t == 41) check("t41_act1", act0[1], 0);
            if (t == 42) begin check("t42_act1", act0[1], 1); check("t42_pulse", sp0, 1); end
            if (t == 181) begin check("t181_pos0", pos0[7:0], 0); check("t181_act0", act0[0], 1); end
            if (t == 182) begin check("t182_act0", act0[0], 0); check("t182_pos0", pos0[7:0], 255); end
            if (t == 1) begin check("s_t1_pulse", sp1, 1); check("s_t1_act", act1, 2'b01); end
            if (t == 2) begin check("s_t2_act", act1, 2'b11); check("s_t2_speed", spd1, 2); end
            if (t == 3) check("s_t3_pulse", sp1, 0);
            if (t == 4) check("s_t4_speed", spd1, 3);
            if (t == 6) check("s_t6_speed", spd1, 3);
            step(0, 0, 0);
        end

        // Type mapping with i_rng = 8'h07.
        step(1, 0, 0);
        for (int t = 1; t <= 42; t++) begin
            step(0, 1, 8'h07);
            if (t == 1)  check("s_type_map", type1[2:0], 1);
            if (t == 21) check("type_map", type0[2:0], 1);
            if (t == 41) check("gap_min_nopulse", sp0, 0);
            if (t == 42) check("gap_min_pulse", sp0, 1);
            step(0, 0, 0);
        end

        // Freeze, ticks ignored, unfreeze does not resume, start+tick clears.
        i_game_frozen = 1;
        step(0, 0, 0);
        saved_pos = e_pos(0); saved_act = e_act(0);
        i_game_frozen = 0;
        for (int t = 0; t < 10; t++) tick(8'($urandom));
        check("frozen_pos", pos0, saved_pos);
        check("frozen_act", act0, saved_act);
        for (int t = 0; t < 5; t++) tick(8'($urandom));
        check("still_frozen_pos", pos0, saved_pos);
        step(1, 1, 8'($urandom));
        check("start_tick_act", act0, 0);
        check("start_tick_pos", pos0, 32'hFFFF_FFFF);
        check("start_tick_pulse", sp0, 0);

        // Long run to reach the speed cap on the default instance.
        for (int t = 0; t < 1900; t++) tick(8'($urandom_range(0, 63)));
        check("speed_cap", spd0, 4);

        // Random mix of ticks, freezes and restarts.
        for (int n = 0; n < 1500; n++) begin
            int a = $urandom_range(0, 99);
            if (a < 3) begin
                i_game_frozen = 1'($urandom_range(0, 1));
                step(1, 1'($urandom_range(0, 1)), 8'($urandom));
                i_game_frozen = 0;
                step(0, 0, 0);
            end else if (a < 5) begin
                i_game_frozen = ~i_game_frozen;
                step(0, 0, 0);
            end else begin
                tick(8'($urandom));
            end
        end
        i_game_frozen = 0;

        // Asynchronous reset mid-operation.
        step(1, 0, 0);
        for (int t = 0; t < 30; t++) tick(8'($urandom_range(0, 15)));
        #2;
        rst = 1;
        #1;
        m_reset();
        compare_all();
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        for (int t = 0; t < 5; t++) tick(8'($urandom));
        check("post_reset_idle_act", act0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
